lab4_decrypt: RTL and testbench
===============================

Name: lab4_decrypt

Overview:
- Downstream consumer of the lab4 encryptor output stream (encryptByte/validOut).
- Recovers the starting LFSR state from the first preamble byte and checks the rest of the preamble.
- Measures the preamble length and strips the preamble, then decrypts each payload byte back to 7-bit ASCII.
- Taps are supplied by the caller (from the ROM word at address 1); the seed is not supplied.

Parameters:
- DW, 8, data byte width (only 8 is supported).
- LW, 5, LFSR width.
- PRE_CHAR, 8'h7E, preamble plaintext character.
- MAX_PRE, 255, preamble length limit; preLen is 8 bits wide.
- MIN_PRE, 7, minimum preamble length; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- decRqst  in  1  one-cycle pulse that arms/restarts a decode.
- taps  in  LW  LFSR feedback taps; sampled on decRqst.
- validIn  in  1  encByte is valid this cycle.
- encByte  in  8  encrypted byte (connects to the encryptor's encryptByte).
- lastIn  in  1  qualifies validIn; this byte is the final one of the stream.
- plainByte  out  8  decrypted byte, bit 7 always 0.
- validOut  out  1  plainByte valid, one cycle per payload byte.
- preLen  out  8  number of preamble bytes seen.
- seedOut  out  LW  recovered starting LFSR state.
- error  out  1  sticky protocol error.
- done  out  1  level; stream finished or aborted on error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0: plainByte, validOut, preLen, seedOut, error, done. LFSR register=0, taps register=0.
- LFSR step: next = {lfsr[LW-2:0], ^(lfsr & tapsReg)}. The LFSR advances exactly once per accepted byte, preamble or payload.
- States: IDLE, SEED, PRE, PAY, FIN.
- IDLE: validIn is ignored. decRqst -> SEED; tapsReg<=taps; preLen, seedOut, error, done cleared.
- SEED, first accepted byte:
  - encByte[7]=1 (payload with no preamble) -> error=1, done=1, go to FIN.
  - encByte[7:5]!=3'b011 -> error=1, done=1, go to FIN.
  - Otherwise seed = encByte[4:0] ^ PRE_CHAR[4:0]; seedOut<=seed; lfsr<=step(seed); preLen<=1; go to PRE.
- PRE, accepted byte:
  - bit7=0: the byte must equal PRE_CHAR ^ {3'b0,lfsr}, else error=1, done=1, go to FIN. On match: preLen+1, LFSR steps.
  - preLen already at MAX_PRE with another preamble byte -> error=1, done=1, go to FIN; preLen holds at 255 (no wrap).
  - bit7=1: payload start. Handled as in PAY, and the state moves to PAY.
- PAY, accepted byte:
  - bit7=0 -> error=1, done=1, go to FIN.
  - Otherwise plainByte <= (encByte ^ {3'b0,lfsr}) & 8'h7F; validOut=1 on the next cycle; LFSR steps.
- Latency: plainByte/validOut are registered, 1 cycle after the accepting edge. Idle gaps in validIn are allowed; the LFSR holds during gaps.
- lastIn with an accepted byte: process the byte normally, then done=1 and go to FIN.
  - A stream that ends inside PRE is legal: done=1, error=0, zero payload bytes.
  - If the same byte also raises an error, both error=1 and done=1.
- FIN: validIn ignored. done and error hold until decRqst, which clears them and restarts in SEED.
- decRqst in any non-IDLE state aborts the current decode and restarts in SEED. Any validIn in that same cycle is ignored.
- validOut is never asserted for preamble bytes or for rejected bytes.

Optional Feature:
- Macro LAB4_DECRYPT_MIN_PRE_CHECK_EN.
- Defined: on the transition to PAY, if preLen < MIN_PRE then error=1, done=1, go to FIN, and that byte is not output. A stream ending in PRE with preLen < MIN_PRE also sets error.
- Undefined: any preamble length from 1 to MAX_PRE is accepted; MIN_PRE is unused.

Test Plan:
- Nominal decode. Stimulus: taps=5'h14, decRqst, then bytes 0x7F, 0x7C, 0x7A, 0xC8 with lastIn on 0xC8. Response: seedOut=5'h01, preLen=3, exactly one validOut with plainByte=0x41 one cycle after 0xC8, then done=1, error=0.
- Preamble corruption. Stimulus: same stream with the 2nd byte 0x7D. Response: error=1, done=1, no validOut; later bytes are ignored.
- Payload first. Stimulus: first byte 0xC8. Response: error=1, done=1, preLen=0.
- Gaps and abort. Stimulus: the nominal stream with 3-cycle validIn gaps. Response: identical outputs. Then decRqst after 0x7C; response: preLen=0, error=0, done=0, fresh SEED.
- Async reset. Stimulus: rst low mid-PAY, off the clock edge. Response: all outputs 0 immediately; decRqst is required before any further decode.
- Option on with MIN_PRE=7. Stimulus: the nominal 3-byte preamble. Response: error=1 at 0xC8, no validOut. Option off: nominal result.

Source files
------------

// File: rtl/lab4_decrypt.sv
// Decryptor for the lab4 LFSR stream: recovers the seed from the preamble, strips it, emits 7-bit ASCII.
// Optional minimum-preamble-length check is enabled by defining LAB4_DECRYPT_MIN_PRE_CHECK_EN.
module lab4_decrypt #(
  parameter int                DW       = 8,
  parameter int                LW       = 5,
  parameter logic [DW-1:0]     PRE_CHAR = 8'h7E,
  parameter int                MAX_PRE  = 255,
  parameter int                MIN_PRE  = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          decRqst,
  input  logic [LW-1:0] taps,
  input  logic          validIn,
  input  logic [7:0]    encByte,
  input  logic          lastIn,
  output logic [7:0]    plainByte,
  output logic          validOut,
  output logic [7:0]    preLen,
  output logic [LW-1:0] seedOut,
  output logic          error,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    PRE  = 3'd2,
    PAY  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_PRE);
`ifdef LAB4_DECRYPT_MIN_PRE_CHECK_EN
  localparam logic [7:0] MIN_LEN = 8'(MIN_PRE);
`else
  // A floor of one is always met once in PRE, so the length checks fall away.
  localparam logic [7:0] MIN_LEN = 8'(MIN_PRE - MIN_PRE + 1);
`endif

  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] cur, input logic [LW-1:0] tp);
    return {cur[LW-2:0], ^(cur & tp)};
  endfunction

  function automatic logic [DW-1:0] pad_lfsr(input logic [LW-1:0] v);
    return {{(DW-LW){1'b0}}, v};
  endfunction

  state_t        state_r, state_s;
  logic [LW-1:0] lfsr_r, lfsr_s;
  logic [LW-1:0] taps_r, taps_s;
  logic [LW-1:0] seed_r, seed_s;
  logic [LW-1:0] seed_rec_s;
  logic [7:0]    pre_len_r, pre_len_s;
  logic [7:0]    plain_r, plain_s;
  logic          valid_r, valid_s;
  logic          error_r, error_s;
  logic          done_r, done_s;
  logic          fail_s, end_s, pay_s;

  assign seed_rec_s = encByte[LW-1:0] ^ PRE_CHAR[LW-1:0];

  // Next-state and next-output decode for the whole decode flow.
  always_comb begin
    state_s   = state_r;
    lfsr_s    = lfsr_r;
    taps_s    = taps_r;
    seed_s    = seed_r;
    pre_len_s = pre_len_r;
    plain_s   = plain_r;
    valid_s   = 1'b0;
    error_s   = error_r;
    done_s    = done_r;
    fail_s    = 1'b0;
    end_s     = 1'b0;
    pay_s     = 1'b0;
    if (decRqst) begin
      state_s   = SEED;
      taps_s    = taps;
      seed_s    = {LW{1'b0}};
      pre_len_s = 8'd0;
      error_s   = 1'b0;
      done_s    = 1'b0;
    end else begin
      case (state_r)
        SEED: begin
          if (validIn) begin
            end_s = lastIn;
            if (encByte[DW-1:LW] != PRE_CHAR[DW-1:LW]) begin
              fail_s = 1'b1;
            end else begin
              seed_s    = seed_rec_s;
              lfsr_s    = lfsr_step(seed_rec_s, taps_r);
              pre_len_s = 8'd1;
              state_s   = PRE;
            end
          end else begin
            end_s = 1'b0;
          end
        end
        PRE: begin
          if (validIn) begin
            end_s = lastIn;
            if (encByte[DW-1]) begin
              if (pre_len_r < MIN_LEN) begin
                fail_s = 1'b1;
              end else begin
                pay_s   = 1'b1;
                state_s = PAY;
              end
            end else if ((pre_len_r == MAX_LEN) || (encByte != (PRE_CHAR ^ pad_lfsr(lfsr_r)))) begin
              fail_s = 1'b1;
            end else begin
              pre_len_s = pre_len_r + 8'd1;
              lfsr_s    = lfsr_step(lfsr_r, taps_r);
            end
          end else begin
            end_s = 1'b0;
          end
        end
        PAY: begin
          if (validIn) begin
            end_s = lastIn;
            if (!encByte[DW-1]) begin
              fail_s = 1'b1;
            end else begin
              pay_s = 1'b1;
            end
          end else begin
            end_s = 1'b0;
          end
        end
        IDLE:    state_s = IDLE;
        FIN:     state_s = FIN;
        default: state_s = IDLE;
      endcase
      if (pay_s) begin
        plain_s = (encByte ^ pad_lfsr(lfsr_r)) & {1'b0, {(DW-1){1'b1}}};
        valid_s = 1'b1;
        lfsr_s  = lfsr_step(lfsr_r, taps_r);
      end else begin
        valid_s = 1'b0;
      end
      // A stream that ends while still in the preamble must also meet the length floor.
      if (end_s && !fail_s && (state_s == PRE) && (pre_len_s < MIN_LEN)) begin
        fail_s = 1'b1;
      end else begin
        fail_s = fail_s;
      end
      if (fail_s) begin
        error_s = 1'b1;
        done_s  = 1'b1;
        state_s = FIN;
      end else if (end_s) begin
        done_s  = 1'b1;
        state_s = FIN;
      end else begin
        done_s  = done_s;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      lfsr_r    <= {LW{1'b0}};
      taps_r    <= {LW{1'b0}};
      seed_r    <= {LW{1'b0}};
      pre_len_r <= 8'd0;
      plain_r   <= 8'd0;
      valid_r   <= 1'b0;
      error_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      lfsr_r    <= lfsr_s;
      taps_r    <= taps_s;
      seed_r    <= seed_s;
      pre_len_r <= pre_len_s;
      plain_r   <= plain_s;
      valid_r   <= valid_s;
      error_r   <= error_s;
      done_r    <= done_s;
    end
  end

  assign plainByte = plain_r;
  assign validOut  = valid_r;
  assign preLen    = pre_len_r;
  assign seedOut   = seed_r;
  assign error     = error_r;
  assign done      = done_r;

endmodule

// File: tb/tb_lab4_decrypt.sv
// Scoreboard bench for lab4_decrypt; expectations adapt when LAB4_DECRYPT_MIN_PRE_CHECK_EN is defined.
module tb_lab4_decrypt;

`ifdef LAB4_DECRYPT_MIN_PRE_CHECK_EN
  localparam bit OPT = 1'b1;
`else
  localparam bit OPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       decRqst;
  logic [4:0] taps;
  logic       validIn;
  logic [7:0] encByte;
  logic       lastIn;
  logic [7:0] plainByte;
  logic       validOut;
  logic [7:0] preLen;
  logic [4:0] seedOut;
  logic       error;
  logic       done;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  lab4_decrypt dut (
    .clk(clk), .rst(rst), .decRqst(decRqst), .taps(taps), .validIn(validIn),
    .encByte(encByte), .lastIn(lastIn), .plainByte(plainByte), .validOut(validOut),
    .preLen(preLen), .seedOut(seedOut), .error(error), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_step(input logic [4:0] s, input logic [4:0] t);
    return {s[3:0], ^(s & t)};
  endfunction

  // Output monitor: every validOut must match the oldest expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst && validOut) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_valid", {24'd0, plainByte}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_value("plain", {24'd0, plainByte}, {24'd0, e});
      end
    end
  end

  task automatic req(input logic [4:0] t);
    decRqst = 1'b1;
    taps    = t;
    @(negedge clk);
    decRqst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    validIn = 1'b1;
    encByte = b;
    lastIn  = last;
    @(negedge clk);
    validIn = 1'b0;
    lastIn  = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [4:0] s, input logic [7:0] pl,
                              input logic er, input logic dn);
    @(negedge clk);
    check_value({tag, "_seed"}, {27'd0, seedOut}, {27'd0, s});
    check_value({tag, "_prelen"}, {24'd0, preLen}, {24'd0, pl});
    check_value({tag, "_error"}, {31'd0, error}, {31'd0, er});
    check_value({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    check_value({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  // Encryptor model: preamble bytes are PRE_CHAR^lfsr, payload bytes set bit 7.
  task automatic run_stream(input logic [4:0] t, input logic [4:0] seed, input int npre, input int npay);
    logic [4:0] lf;
    logic [6:0] p;
    lf = seed;
    req(t);
    for (int i = 0; i < npre; i++) begin
      send_byte(8'h7E ^ {3'b000, lf}, (npay == 0) && (i == npre - 1));
      lf = model_step(lf, t);
    end
    for (int j = 0; j < npay; j++) begin
      p = 7'($urandom_range(0, 127));
      if (!(OPT && npre < 7)) exp_q.push_back({1'b0, p});
      send_byte({1'b1, p} ^ {3'b000, lf}, j == npay - 1);
      lf = model_step(lf, t);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] t;
    logic [4:0] s;
    rst = 1'b0; decRqst = 1'b0; taps = 5'd0; validIn = 1'b0; encByte = 8'd0; lastIn = 1'b0;
    #3;
    check_value("rst_plain", {24'd0, plainByte}, 32'd0);
    check_value("rst_valid", {31'd0, validOut}, 32'd0);
    check_value("rst_prelen", {24'd0, preLen}, 32'd0);
    check_value("rst_seed", {27'd0, seedOut}, 32'd0);
    check_value("rst_error", {31'd0, error}, 32'd0);
    check_value("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Nominal decode
    req(5'h14);
    send_byte(8'h7F, 1'b0); send_byte(8'h7C, 1'b0); send_byte(8'h7A, 1'b0);
    if (!OPT) exp_q.push_back(8'h41);
    send_byte(8'hC8, 1'b1);
    check_status("nominal", 5'h01, 8'd3, OPT, 1'b1);

    // Preamble corruption, trailing bytes ignored
    req(5'h14);
    send_byte(8'h7F, 1'b0); send_byte(8'h7D, 1'b0); send_byte(8'h7A, 1'b0); send_byte(8'hC8, 1'b1);
    check_status("corrupt", 5'h01, 8'd1, 1'b1, 1'b1);

    // Payload first
    req(5'h14);
    send_byte(8'hC8, 1'b1);
    check_status("payfirst", 5'h00, 8'd0, 1'b1, 1'b1);

    // Nominal with gaps
    req(5'h14);
    send_byte(8'h7F, 1'b0); repeat (3) @(negedge clk);
    send_byte(8'h7C, 1'b0); repeat (3) @(negedge clk);
    send_byte(8'h7A, 1'b0); repeat (3) @(negedge clk);
    if (!OPT) exp_q.push_back(8'h41);
    send_byte(8'hC8, 1'b1);
    check_status("gaps", 5'h01, 8'd3, OPT, 1'b1);

    // Abort after 0x7C, then a fresh decode
    req(5'h14);
    send_byte(8'h7F, 1'b0); send_byte(8'h7C, 1'b0);
    req(5'h14);
    check_value("abort_prelen", {24'd0, preLen}, 32'd0);
    check_value("abort_error", {31'd0, error}, 32'd0);
    check_value("abort_done", {31'd0, done}, 32'd0);
    send_byte(8'h7F, 1'b0); send_byte(8'h7C, 1'b0); send_byte(8'h7A, 1'b0);
    if (!OPT) exp_q.push_back(8'h41);
    send_byte(8'hC8, 1'b1);
    check_status("restart", 5'h01, 8'd3, OPT, 1'b1);

    // Random taps/seed, long preamble, multi-byte payload
    for (int k = 0; k < 3; k++) begin
      t = 5'($urandom_range(1, 31));
      s = 5'($urandom_range(1, 31));
      run_stream(t, s, 8 + k, 5);
      check_status("random", s, 8'(8 + k), 1'b0, 1'b1);
    end

    // Stream ending inside the preamble
    run_stream(5'h12, 5'h0B, 8, 0);
    check_status("prelast", 5'h0B, 8'd8, 1'b0, 1'b1);
    run_stream(5'h12, 5'h0B, 3, 0);
    check_status("preshort", 5'h0B, 8'd3, OPT, 1'b1);

    // Preamble length limit: the 256th preamble byte is rejected
    run_stream(5'h14, 5'h05, 256, 0);
    check_status("maxpre", 5'h05, 8'd255, 1'b1, 1'b1);

    // Async reset mid-payload
    run_stream(5'h09, 5'h13, 8, 0);
    check_status("prebuild", 5'h13, 8'd8, 1'b0, 1'b1);
    req(5'h14);
    send_byte(8'h7F, 1'b0); send_byte(8'h7C, 1'b0); send_byte(8'h7A, 1'b0);
    if (!OPT) exp_q.push_back(8'h41);
    send_byte(8'hC8, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_value("arst_plain", {24'd0, plainByte}, 32'd0);
    check_value("arst_valid", {31'd0, validOut}, 32'd0);
    check_value("arst_prelen", {24'd0, preLen}, 32'd0);
    check_value("arst_seed", {27'd0, seedOut}, 32'd0);
    check_value("arst_error", {31'd0, error}, 32'd0);
    check_value("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h7F, 1'b0); send_byte(8'h7C, 1'b0); send_byte(8'hC8, 1'b1);
    check_status("postrst", 5'h00, 8'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
